// File: rtl/qam_pkg.sv
// Shared definitions for the 64-QAM FIFO read scheduler: symbol width,
// the idle symbol used on starvation, and the scheduler state encoding.
package qam_pkg;

    localparam int SYM_WIDTH = 6;
    localparam logic [SYM_WIDTH-1:0] IDLE_SYMBOL = 6'b000000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_PRESENT = 3'd4
    } qam_state_e;

endpackage

// File: rtl/qam_fifo_read_scheduler_if.sv
// Bus between the scheduler, the sync FIFO read side and the 64-QAM mapper.
//
// Symbol handshake: sym_data is transferred in a cycle where sym_valid and
// sym_ready are both high. Once sym_valid rises, sym_valid and sym_data stay
// stable until that transfer cycle; sym_ready may be asserted at any time and
// has no effect while sym_valid is low.
//
// FIFO side: fifo_read_enable is a single-cycle request; fifo_read_ack in the
// same cycle means the read was accepted and fifo_data carries the word on
// the following cycle.
interface qam_fifo_read_scheduler_if;
    import qam_pkg::*;

    logic                 fifo_read_enable;
    logic                 fifo_read_ack;
    logic                 fifo_empty;
    logic [SYM_WIDTH-1:0] fifo_data;
    logic [SYM_WIDTH-1:0] sym_data;
    logic                 sym_valid;
    logic                 sym_ready;

    // Scheduler side
    modport master (
        output fifo_read_enable,
        output sym_data,
        output sym_valid,
        input  fifo_read_ack,
        input  fifo_empty,
        input  fifo_data,
        input  sym_ready
    );

    // FIFO + mapper side
    modport slave (
        input  fifo_read_enable,
        input  sym_data,
        input  sym_valid,
        output fifo_read_ack,
        output fifo_empty,
        output fifo_data,
        output sym_ready
    );

endinterface

// File: rtl/qam_symbol_tick_gen.sv
// Symbol-rate tick generator: a reloadable down-counter that fires one tick
// each time it reaches zero while counting, then reloads the period.
module qam_symbol_tick_gen #(
    parameter int RATE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  count_en_i,
    input  logic                  load_i,
    input  logic [RATE_WIDTH-1:0] rate_div_i,
    output logic                  tick_o
);

    logic [RATE_WIDTH-1:0] cnt_q;
    logic [RATE_WIDTH-1:0] cnt_d;

    // A tick is only produced while counting; a held or loading counter is silent.
    assign tick_o = count_en_i && (cnt_q == '0);

    // Next count: load wins, otherwise count down and reload on zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = rate_div_i;
        end else if (count_en_i) begin
            if (cnt_q == '0) begin
                cnt_d = rate_div_i;
            end else begin
                cnt_d = cnt_q - RATE_WIDTH'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/qam_fifo_read_scheduler.sv
// Paces FIFO reads into the 64-QAM mapper at a programmable symbol rate.
// One read per symbol tick; the RAM word is captured the cycle after an
// accepted read and offered to the mapper. Starvation substitutes the idle
// symbol, pulses underrun and bumps a saturating counter.
module qam_fifo_read_scheduler
    import qam_pkg::*;
#(
    parameter int RATE_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [RATE_WIDTH-1:0]       rate_div,
    qam_fifo_read_scheduler_if.master   bus,
    output logic                        underrun,
    output logic                        late,
    output logic [CNT_WIDTH-1:0]        underrun_count,
    output logic                        busy,
    output qam_state_e                  dbg_state
);

    qam_state_e           state_q, state_d;
    logic                 pending_q, pending_d;
    logic [SYM_WIDTH-1:0] sym_data_q, sym_data_d;
    logic                 sym_valid_q, sym_valid_d;
    logic                 underrun_q, underrun_d;
    logic [CNT_WIDTH-1:0] ucnt_q, ucnt_d;
    logic                 take_underrun;
    logic                 tick;
    logic                 tick_count_en;
    logic                 tick_load;

    // Counter runs only while enabled outside IDLE and is reloaded in IDLE.
    assign tick_count_en = enable && (state_q != ST_IDLE);
    assign tick_load     = (state_q == ST_IDLE);

    qam_symbol_tick_gen #(
        .RATE_WIDTH (RATE_WIDTH)
    ) u_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_en_i (tick_count_en),
        .load_i     (tick_load),
        .rate_div_i (rate_div),
        .tick_o     (tick)
    );

    // The read request is a pure decode of READ, so it can never repeat or
    // overlap a presented symbol.
    assign bus.fifo_read_enable = (state_q == ST_READ);
    assign bus.sym_data         = sym_data_q;
    assign bus.sym_valid        = sym_valid_q;
    assign underrun             = underrun_q;
    assign underrun_count       = ucnt_q;
    assign busy                 = (state_q != ST_IDLE);
    assign dbg_state            = state_q;
    // A tick arriving on top of an unserved one is dropped and flagged.
    assign late                 = tick && pending_q;

    // Next-state, pending tracking, symbol register and underrun bookkeeping.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q | tick;
        sym_data_d    = sym_data_q;
        sym_valid_d   = sym_valid_q;
        underrun_d    = 1'b0;
        ucnt_d        = ucnt_q;
        take_underrun = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                pending_d = 1'b0;
                if (enable) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    pending_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (pending_q || tick) begin
                    // A tick in this very cycle is served at once, which
                    // keeps tick-to-valid at three cycles.
                    pending_d = 1'b0;
                    if (!bus.fifo_empty) begin
                        state_d = ST_READ;
                    end else begin
                        take_underrun = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (bus.fifo_read_ack) begin
                    state_d = ST_CAPTURE;
                end else begin
                    take_underrun = 1'b1;
                end
            end
            ST_CAPTURE: begin
                sym_data_d  = bus.fifo_data;
                sym_valid_d = 1'b1;
                state_d     = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.sym_ready) begin
                    sym_valid_d = 1'b0;
                    if (enable) begin
                        state_d = ST_WAIT;
                    end else begin
                        pending_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                pending_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        if (take_underrun) begin
            sym_data_d  = IDLE_SYMBOL;
            sym_valid_d = 1'b1;
            underrun_d  = 1'b1;
            if (ucnt_q != {CNT_WIDTH{1'b1}}) begin
                ucnt_d = ucnt_q + CNT_WIDTH'(1);
            end
            state_d = ST_PRESENT;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            sym_data_q  <= '0;
            sym_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            sym_data_q  <= sym_data_d;
            sym_valid_q <= sym_valid_d;
            underrun_q  <= underrun_d;
            ucnt_q      <= ucnt_d;
        end
    end

endmodule

// File: tb/tb_qam_fifo_read_scheduler.sv
// Bench for qam_fifo_read_scheduler: a small FIFO model on the read side,
// a cycle table for steady flow, and hand-written multi-cycle sequences.
module tb_qam_fifo_read_scheduler;
    import qam_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [7:0]       rate_div = 8'd0;
    logic             underrun;
    logic             late;
    logic [15:0]      underrun_count;
    logic             busy;
    qam_state_e       dut_state;

    qam_fifo_read_scheduler_if bus();

    qam_fifo_read_scheduler #(
        .RATE_WIDTH (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .rate_div       (rate_div),
        .bus            (bus),
        .underrun       (underrun),
        .late           (late),
        .underrun_count (underrun_count),
        .busy           (busy),
        .dbg_state      (dut_state)
    );

    // Clock
    always #5 clk = ~clk;

    // FIFO model: registered empty flag (pointers), same-cycle ack, data a cycle later.
    logic [5:0] fifo_mem [0:15];
    logic [3:0] rd_ptr = 4'd0;
    logic [3:0] wr_ptr = 4'd0;
    logic       ack_block = 1'b0;
    logic       sym_ready = 1'b0;

    always_comb bus.fifo_empty = (rd_ptr == wr_ptr);
    always_comb bus.fifo_read_ack = bus.fifo_read_enable && (rd_ptr != wr_ptr) && !ack_block;
    always_comb bus.sym_ready = sym_ready;

    initial bus.fifo_data = 6'd0;
    always @(posedge clk) begin
        if (bus.fifo_read_ack) begin
            bus.fifo_data <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 4'd1;
        end
    end

    // Scoreboard counters
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fifo_load(input logic [5:0] v);
        fifo_mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    // Reset with FIFO flushed; returns at posedge+1 with the DUT in IDLE.
    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        sym_ready = 1'b0;
        ack_block = 1'b0;
        repeat (2) @(posedge clk);
        wr_ptr = rd_ptr;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for sym_valid; returns at a negedge.
    task automatic wait_valid(input int max_cyc, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.sym_valid) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 32'(found), 32'd1);
    endtask

    typedef struct {
        logic       en;
        logic       rdy;
        logic       busy;
        logic       rd;
        logic       vld;
        logic [5:0] data;
        logic       urun;
        logic       lt;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic rdy, input logic b, input logic rd,
                                input logic vld, input logic [5:0] data);
        vec_t v;
        v.en = en; v.rdy = rdy; v.busy = b; v.rd = rd; v.vld = vld; v.data = data;
        v.urun = 1'b0; v.lt = 1'b0;
        return v;
    endfunction

    vec_t tbl [17];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [5:0] held;
        int n_und;
        int last_c;
        int reads;
        logic found;

        // Steady flow, rate_div=3: tick at cycle 4, then every 4 cycles.
        tbl[0]  = mk(1, 1, 0, 0, 0, 6'h00);
        tbl[1]  = mk(1, 1, 1, 0, 0, 6'h00);
        tbl[2]  = mk(1, 1, 1, 0, 0, 6'h00);
        tbl[3]  = mk(1, 1, 1, 0, 0, 6'h00);
        tbl[4]  = mk(1, 1, 1, 0, 0, 6'h00);
        tbl[5]  = mk(1, 1, 1, 1, 0, 6'h00);
        tbl[6]  = mk(1, 1, 1, 0, 0, 6'h00);
        tbl[7]  = mk(1, 1, 1, 0, 1, 6'h15);
        tbl[8]  = mk(1, 1, 1, 0, 0, 6'h00);
        tbl[9]  = mk(1, 1, 1, 1, 0, 6'h00);
        tbl[10] = mk(1, 1, 1, 0, 0, 6'h00);
        tbl[11] = mk(1, 1, 1, 0, 1, 6'h2A);
        tbl[12] = mk(1, 1, 1, 0, 0, 6'h00);
        tbl[13] = mk(1, 1, 1, 1, 0, 6'h00);
        tbl[14] = mk(1, 1, 1, 0, 0, 6'h00);
        tbl[15] = mk(0, 1, 1, 0, 1, 6'h3F);
        tbl[16] = mk(0, 1, 0, 0, 0, 6'h00);

        // Reset state, checked while reset is held.
        #1;
        check("reset_valid", 32'(bus.sym_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(underrun_count), 32'd0);
        check("reset_rd_en", 32'(bus.fifo_read_enable), 32'd0);
        check("reset_state", 32'(dut_state), 32'(ST_IDLE));

        // ---- Steady flow ----
        rate_div = 8'd3;
        do_reset();
        fifo_load(6'h15);
        fifo_load(6'h2A);
        fifo_load(6'h3F);
        for (int i = 0; i < 17; i++) begin
            enable = tbl[i].en;
            sym_ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("steady_busy[%0d]", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("steady_rd[%0d]", i), 32'(bus.fifo_read_enable), 32'(tbl[i].rd));
            check($sformatf("steady_valid[%0d]", i), 32'(bus.sym_valid), 32'(tbl[i].vld));
            if (tbl[i].vld)
                check($sformatf("steady_data[%0d]", i), 32'(bus.sym_data), 32'(tbl[i].data));
            check($sformatf("steady_underrun[%0d]", i), 32'(underrun), 32'(tbl[i].urun));
            check($sformatf("steady_late[%0d]", i), 32'(late), 32'(tbl[i].lt));
            @(posedge clk);
            #1;
        end
        check("steady_count", 32'(underrun_count), 32'd0);

        // ---- Starvation: empty FIFO, rate_div=1 ----
        rate_div = 8'd1;
        do_reset();
        sym_ready = 1'b1;
        enable = 1'b1;
        n_und = 0;
        last_c = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("starve_rd_en", 32'(bus.fifo_read_enable), 32'd0);
            if (bus.sym_valid) begin
                check("starve_data", 32'(bus.sym_data), 32'(IDLE_SYMBOL));
                check("starve_underrun", 32'(underrun), 32'd1);
                check("starve_count", 32'(underrun_count), 32'(n_und + 1));
                if (last_c >= 0) check("starve_gap", 32'(c - last_c), 32'd2);
                last_c = c;
                n_und++;
            end
            @(posedge clk);
            #1;
        end
        check("starve_symbols", 32'(n_und), 32'd5);

        // ---- Backpressure: rate_div=0, mapper stalled ----
        rate_div = 8'd0;
        do_reset();
        fifo_load(6'h11);
        fifo_load(6'h22);
        enable = 1'b1;
        reads = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (bus.fifo_read_enable) reads++;
            if (c >= 3) check($sformatf("bp_late[%0d]", c), 32'(late), 32'd1);
            if (c >= 4) begin
                check($sformatf("bp_valid[%0d]", c), 32'(bus.sym_valid), 32'd1);
                check($sformatf("bp_data[%0d]", c), 32'(bus.sym_data), 32'h11);
            end
            @(posedge clk);
            #1;
        end
        check("bp_reads", 32'(reads), 32'd1);
        sym_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_valid", 32'(bus.sym_valid), 32'd1);
        @(posedge clk);
        #1;
        sym_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (bus.fifo_read_enable) found = 1'b1;
            if (found) break;
            @(posedge clk);
            #1;
        end
        check("bp_next_read", 32'(found), 32'd1);
        wait_valid(5, "bp_second_valid");
        check("bp_second_data", 32'(bus.sym_data), 32'h22);
        check("bp_no_underrun", 32'(underrun_count), 32'd0);

        // ---- Ack withheld during READ ----
        do_reset();
        fifo_load(6'h05);
        ack_block = 1'b1;
        enable = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.fifo_read_enable) begin
                found = 1'b1;
                break;
            end
        end
        check("nack_read_seen", 32'(found), 32'd1);
        check("nack_fifo_nonempty", 32'(bus.fifo_empty), 32'd0);
        @(negedge clk);
        check("nack_valid", 32'(bus.sym_valid), 32'd1);
        check("nack_data", 32'(bus.sym_data), 32'(IDLE_SYMBOL));
        check("nack_underrun", 32'(underrun), 32'd1);
        check("nack_count", 32'(underrun_count), 32'd1);
        @(negedge clk);
        check("nack_underrun_pulse", 32'(underrun), 32'd0);
        check("nack_valid_held", 32'(bus.sym_valid), 32'd1);

        // ---- Enable drop in CAPTURE ----
        do_reset();
        fifo_load(6'h2B);
        sym_ready = 1'b1;
        enable = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dut_state == ST_CAPTURE) begin
                found = 1'b1;
                break;
            end
        end
        check("drop_capture_seen", 32'(found), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("drop_valid", 32'(bus.sym_valid), 32'd1);
        check("drop_data", 32'(bus.sym_data), 32'h2B);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("drop_busy", 32'(busy), 32'd0);
            check("drop_rd_en", 32'(bus.fifo_read_enable), 32'd0);
        end

        // ---- Reset during PRESENT ----
        do_reset();
        enable = 1'b1;
        wait_valid(6, "rst_present_valid");
        check("rst_pre_count", 32'(underrun_count), 32'd1);
        held = bus.sym_data;
        check("rst_pre_data", 32'(held), 32'(IDLE_SYMBOL));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(bus.sym_valid), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_count", 32'(underrun_count), 32'd0);
        check("rst_async_underrun", 32'(underrun), 32'd0);
        @(posedge clk);
        fifo_load(6'h3C);
        sym_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_state", 32'(dut_state), 32'(ST_IDLE));
        wait_valid(8, "rst_restart_valid");
        check("rst_restart_data", 32'(bus.sym_data), 32'h3C);
        enable = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qam_fifo_read_scheduler.md
Name: qam_fifo_read_scheduler

Overview:
- Paces reads from the sync FIFO read side into the 64-QAM mapper at a programmable symbol rate.
- Issues one FIFO read request per symbol tick and captures the FIFO RAM output one cycle after an accepted read.
- Presents the captured 6-bit symbol to the mapper over a valid/ready handshake.
- On FIFO starvation, substitutes an idle symbol and reports the underrun.

Parameters:
SYM_WIDTH, 6, bits per 64-QAM symbol (I/Q 3+3)
RATE_WIDTH, 8, width of symbol-period divider
IDLE_SYMBOL, 6'b000000, symbol emitted on underrun
CNT_WIDTH, 16, width of saturating underrun counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  run request; level
rate_div  input  RATE_WIDTH  symbol period minus 1, in clk cycles; sampled on each counter reload
fifo_empty  input  1  FIFO empty flag (registered in FIFO)
fifo_read_enable  output  1  read request to FIFO read_enable
fifo_read_ack  input  1  FIFO read_enable_out; read accepted, same cycle as request
fifo_data  input  SYM_WIDTH  FIFO RAM data, valid the cycle after an accepted read
sym_data  output  SYM_WIDTH  symbol to mapper
sym_valid  output  1  sym_data valid
sym_ready  input  1  mapper accepts symbol
underrun  output  1  one-cycle pulse when IDLE_SYMBOL is substituted
late  output  1  one-cycle pulse when a tick arrives while one is already pending
underrun_count  output  CNT_WIDTH  saturating count of underruns
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state=IDLE; tick counter=0; pending=0; underrun_count=0.

Tick counter:
- While enable=1 and state!=IDLE: counts down to 0; at 0 generates tick and reloads rate_div.
- rate_div=0 gives a tick every cycle.
- In IDLE the counter is loaded with rate_div.
- tick sets pending. tick while pending=1 pulses late; pending stays 1 (one-deep, no accumulation).

FSM states: IDLE, WAIT, READ, CAPTURE, PRESENT.
- IDLE: when enable=1 -> WAIT.
- WAIT:
  - If enable=0 -> IDLE.
  - Else if pending=1:
    - fifo_empty=0 -> READ.
    - fifo_empty=1 -> load sym_data=IDLE_SYMBOL, sym_valid=1, pulse underrun, increment underrun_count (saturate at all-ones) -> PRESENT.
  - In both cases pending clears.
- READ: fifo_read_enable=1 for exactly this cycle (combinational from state).
  - fifo_read_ack=1 -> CAPTURE.
  - fifo_read_ack=0 -> underrun path identical to WAIT (IDLE_SYMBOL, pulse, count) -> PRESENT.
- CAPTURE: sym_data<=fifo_data, sym_valid<=1 -> PRESENT.
  - Latency from tick to sym_valid: 3 cycles normal (WAIT, READ, CAPTURE), 1 cycle on underrun.
- PRESENT: hold sym_data/sym_valid stable until sym_ready=1.
  - In the ready cycle: sym_valid<=0 -> WAIT.
  - If a tick pending and enable=1, the next request starts the following cycle.
- enable=0 mid-operation: current symbol completes through PRESENT handshake, then IDLE. No FIFO read is issued after enable falls, and pending is cleared on entering IDLE.
- fifo_read_enable is never asserted outside READ, never for two consecutive cycles, and never while sym_valid=1.
- Ticks keep counting during PRESENT backpressure; surplus ticks are reported via late only.
- Simultaneous tick and sym_ready in PRESENT: handshake completes and pending=1; WAIT acts on it next cycle.

Decomposition:
- Shared package qam_pkg: SYM_WIDTH, IDLE_SYMBOL, and the state enum encoding (IDLE=0, WAIT=1, READ=2, CAPTURE=3, PRESENT=4, 3 bits).
- One natural sub-module, qam_symbol_tick_gen: reloadable down-counter with tick output, enable, and rate_div input.
- FSM, capture register and underrun counter stay in the top.

Test Plan:
- Steady flow: rate_div=3, FIFO preloaded 0x15,0x2A,0x3F, sym_ready=1 -> sym_valid pulses every 4 cycles with 0x15,0x2A,0x3F. First sym_valid 3 cycles after first tick. No underrun.
- Starvation: empty FIFO, enable=1, rate_div=1 -> sym_data=0x00 every 2 cycles, underrun pulses, underrun_count increments 1,2,3; fifo_read_enable never asserted.
- Backpressure: rate_div=0, sym_ready=0 for 10 cycles -> sym_data stable, exactly one read issued, late pulses each cycle after pending is set. On sym_ready=1, the next read occurs within 2 cycles.
- Ack withheld: force fifo_read_ack=0 during READ with fifo_empty=0 -> IDLE_SYMBOL presented, underrun=1 for one cycle.
- Enable drop mid-symbol: deassert enable in CAPTURE -> symbol still presented and accepted, then busy=0, no further fifo_read_enable.
- Reset mid-PRESENT: rst_n low with sym_valid=1 -> sym_valid, busy, underrun_count = 0 immediately (asynchronous). After release, enable=1 restarts from IDLE.
